// File: rtl/calc_entry_pkg.sv
// Shared types and limits for the decimal operand entry front end.
// Imported by the entry FSM and its button debouncers.
package calc_entry_pkg;

  typedef enum logic {
    ENTRY = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam int MAX_DIGITS  = 3;
  localparam int BCD_MAX     = 9;
  localparam int OPERAND_MAX = 255;

  // Appends one decimal digit; 12 bits is wide enough that overflow is visible.
  function automatic logic [11:0] shift_in(
    input logic [7:0] acc,
    input logic [3:0] d
  );
    return 12'(acc) * 12'd10 + 12'(d);
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser, stability counter and rising-edge pulse
// for one raw push-button.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic rise
);

  logic             s1;
  logic             s2;
  logic             lvl;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      lvl  <= 1'b0;
      cnt  <= '0;
      rise <= 1'b0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      rise <= 1'b0;
      if (s2 == lvl) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
        lvl  <= s2;
        cnt  <= '0;
        rise <= s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/decimal_operand_entry.sv
// Debounced keypad front end: builds a binary operand from decimal
// digits and hands it to the core over a valid/ack handshake.
module decimal_operand_entry
  import calc_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] digit_sw,
  input  logic [3:0] op_sw,
  input  logic       digit_btn,
  input  logic       enter_btn,
  input  logic       clear_btn,
  input  logic       operand_ack,
  output logic [7:0] acc_value,
  output logic [1:0] digit_count,
  output logic [7:0] operand,
  output logic [3:0] op_code,
  output logic       operand_valid,
  output logic       clear_pulse,
  output logic       entry_error
);

  logic        dig_ev;
  logic        ent_ev;
  logic        clr_ev;
  logic [7:0]  acc;
  logic [11:0] t;
  state_t      state;

  assign acc_value = acc;
  assign t         = shift_in(acc, digit_sw);

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W(CNT_W)
  ) u_dig (
    .clock(clock),
    .reset(reset),
    .raw(digit_btn),
    .rise(dig_ev)
  );

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W(CNT_W)
  ) u_ent (
    .clock(clock),
    .reset(reset),
    .raw(enter_btn),
    .rise(ent_ev)
  );

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W(CNT_W)
  ) u_clr (
    .clock(clock),
    .reset(reset),
    .raw(clear_btn),
    .rise(clr_ev)
  );

  // Clear wins over everything; enter wins over digit; losers are dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ENTRY;
      acc           <= '0;
      digit_count   <= '0;
      operand       <= '0;
      op_code       <= '0;
      operand_valid <= 1'b0;
      clear_pulse   <= 1'b0;
      entry_error   <= 1'b0;
    end else begin
      clear_pulse <= clr_ev;
      if (clr_ev) begin
        state         <= ENTRY;
        acc           <= '0;
        digit_count   <= '0;
        operand_valid <= 1'b0;
        entry_error   <= 1'b0;
      end else begin
        unique case (state)
          ENTRY: begin
            if (ent_ev) begin
              operand       <= acc;
              op_code       <= op_sw;
              operand_valid <= 1'b1;
              acc           <= '0;
              digit_count   <= '0;
              entry_error   <= 1'b0;
              state         <= HOLD;
            end else if (dig_ev) begin
              if (digit_sw > 4'(BCD_MAX)) begin
                entry_error <= 1'b1;
              end else if (digit_count == 2'(MAX_DIGITS)) begin
                entry_error <= 1'b1;
              end else if (t > 12'(OPERAND_MAX)) begin
                entry_error <= 1'b1;
              end else begin
                acc         <= t[7:0];
                digit_count <= digit_count + 2'd1;
              end
            end
          end
          HOLD: begin
            if (operand_ack) begin
              operand_valid <= 1'b0;
              state         <= ENTRY;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_decimal_operand_entry.sv
// Randomised and directed bench for decimal_operand_entry against
// a behavioural model of the keypad, checked on every cycle.
module tb_decimal_operand_entry;

  localparam int DB = 4;
  localparam int HL = DB + 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] digit_sw = '0;
  logic [3:0] op_sw = '0;
  logic       digit_btn = 1'b0;
  logic       enter_btn = 1'b0;
  logic       clear_btn = 1'b0;
  logic       operand_ack = 1'b0;
  logic [7:0] acc_value;
  logic [1:0] digit_count;
  logic [7:0] operand;
  logic [3:0] op_code;
  logic       operand_valid;
  logic       clear_pulse;
  logic       entry_error;

  int total = 0;
  int bad = 0;

  // model state
  int m_acc, m_cnt, m_opnd, m_opc;
  int m_valid, m_cp, m_err;
  logic [HL-1:0] hist [3];
  logic lvl [3];
  logic ev [3];

  decimal_operand_entry #(
    .DEBOUNCE_CYCLES(DB),
    .CNT_W(3)
  ) dut (
    .clock(clock),
    .reset(reset),
    .digit_sw(digit_sw),
    .op_sw(op_sw),
    .digit_btn(digit_btn),
    .enter_btn(enter_btn),
    .clear_btn(clear_btn),
    .operand_ack(operand_ack),
    .acc_value(acc_value),
    .digit_count(digit_count),
    .operand(operand),
    .op_code(op_code),
    .operand_valid(operand_valid),
    .clear_pulse(clear_pulse),
    .entry_error(entry_error)
  );

  always #5 clock = ~clock;

  task automatic cmp(input string n, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               n, a, e, $time);
    end
  endtask

  // Behavioural update for one rising edge; events act one edge
  // after they are recognised.
  task automatic model_edge();
    logic rin [3];
    logic all_diff;
    int nv;
    rin[0] = digit_btn;
    rin[1] = enter_btn;
    rin[2] = clear_btn;
    if (reset) begin
      m_acc = 0; m_cnt = 0; m_opnd = 0; m_opc = 0;
      m_valid = 0; m_cp = 0; m_err = 0;
    end else begin
      m_cp = int'(ev[2]);
      if (ev[2]) begin
        m_acc = 0; m_cnt = 0; m_err = 0; m_valid = 0;
      end else if (m_valid == 0) begin
        if (ev[1]) begin
          m_opnd = m_acc; m_opc = int'(op_sw);
          m_valid = 1; m_acc = 0; m_cnt = 0; m_err = 0;
        end else if (ev[0]) begin
          nv = m_acc * 10 + int'(digit_sw);
          if (digit_sw > 9 || m_cnt == 3 || nv > 255) m_err = 1;
          else begin
            m_acc = nv; m_cnt++;
          end
        end
      end else if (operand_ack) begin
        m_valid = 0;
      end
    end
    // a level flips once the input has disagreed with it for DB+1
    // consecutive samples, seen two edges late through the synchroniser
    for (int b = 0; b < 3; b++) begin
      if (reset) begin
        hist[b] = '0; lvl[b] = 1'b0; ev[b] = 1'b0;
      end else begin
        hist[b] = {hist[b][HL-2:0], rin[b]};
        all_diff = 1'b1;
        for (int j = 2; j <= DB + 2; j++)
          if (hist[b][j] == lvl[b]) all_diff = 1'b0;
        ev[b] = 1'b0;
        if (all_diff) begin
          lvl[b] = ~lvl[b];
          ev[b] = lvl[b];
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    cmp("acc_value", int'(acc_value), m_acc);
    cmp("digit_count", int'(digit_count), m_cnt);
    cmp("operand", int'(operand), m_opnd);
    cmp("op_code", int'(op_code), m_opc);
    cmp("operand_valid", int'(operand_valid), m_valid);
    cmp("clear_pulse", int'(clear_pulse), m_cp);
    cmp("entry_error", int'(entry_error), m_err);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press(input logic d, input logic e,
                       input logic c, input int len);
    digit_btn = d; enter_btn = e; clear_btn = c;
    ticks(len);
    digit_btn = 0; enter_btn = 0; clear_btn = 0;
    ticks(10);
  endtask

  task automatic key(input logic [3:0] d);
    digit_sw = d;
    press(1, 0, 0, 6);
  endtask

  task automatic ack();
    operand_ack = 1; tick(); operand_ack = 0; tick();
  endtask

  initial begin
    int np;
    int len, gap;
    for (int b = 0; b < 3; b++) begin
      hist[b] = '0; lvl[b] = 0; ev[b] = 0;
    end
    ticks(3);
    reset = 0;
    cmp("rst_acc", int'(acc_value), 0);
    cmp("rst_operand", int'(operand), 0);
    cmp("rst_valid", int'(operand_valid), 0);

    key(1); key(2); key(3);
    cmp("k123_acc", int'(acc_value), 123);
    cmp("k123_cnt", int'(digit_count), 3);
    op_sw = 4'h2;
    press(0, 1, 0, 6);
    cmp("c123_operand", int'(operand), 123);
    cmp("c123_opcode", int'(op_code), 2);
    cmp("c123_valid", int'(operand_valid), 1);
    cmp("c123_acc", int'(acc_value), 0);
    cmp("c123_cnt", int'(digit_count), 0);
    ack();
    cmp("ack_valid", int'(operand_valid), 0);

    key(2); key(5); key(6);
    cmp("k256_err", int'(entry_error), 1);
    cmp("k256_acc", int'(acc_value), 25);
    cmp("k256_cnt", int'(digit_count), 2);
    press(0, 1, 0, 6);
    cmp("c25_operand", int'(operand), 25);
    cmp("c25_err", int'(entry_error), 0);
    ack();

    key(4'hA);
    cmp("bcd_err", int'(entry_error), 1);
    cmp("bcd_acc", int'(acc_value), 0);
    np = 0;
    clear_btn = 1;
    for (int k = 0; k < 20; k++) begin
      if (k == 6) clear_btn = 0;
      tick();
      if (clear_pulse) np++;
    end
    cmp("clear_pulses", np, 1);
    cmp("clear_err", int'(entry_error), 0);
    key(1); key(1); key(1);
    cmp("k111_err", int'(entry_error), 0);
    key(1);
    cmp("k1111_err", int'(entry_error), 1);
    cmp("k1111_acc", int'(acc_value), 111);

    press(0, 0, 1, 6);
    digit_sw = 4'd3;
    digit_btn = 1; ticks(3); digit_btn = 0; ticks(10);
    cmp("glitch_acc", int'(acc_value), 0);
    digit_sw = 4'd7;
    digit_btn = 1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 7) cmp("pre_event_acc", int'(acc_value), 0);
      if (k == 8) cmp("post_event_acc", int'(acc_value), 7);
    end
    digit_btn = 0; ticks(10);
    cmp("hold10_acc", int'(acc_value), 7);

    press(0, 1, 0, 6);
    op_sw = 4'h9;
    key(5);
    press(0, 1, 0, 6);
    cmp("hold_acc", int'(acc_value), 0);
    cmp("hold_operand", int'(operand), 7);
    cmp("hold_opcode", int'(op_code), 2);
    clear_btn = 1; ticks(7);
    operand_ack = 1; tick(); operand_ack = 0;
    clear_btn = 0;
    cmp("clr_ack_pulse", int'(clear_pulse), 1);
    cmp("clr_ack_valid", int'(operand_valid), 0);
    cmp("clr_ack_operand", int'(operand), 7);
    tick();
    cmp("clr_ack_pulse_end", int'(clear_pulse), 0);
    ticks(10);

    key(1); key(2);
    digit_sw = 4'd5;
    press(1, 1, 0, 6);
    cmp("coin_operand", int'(operand), 12);
    cmp("coin_acc", int'(acc_value), 0);
    cmp("coin_cnt", int'(digit_count), 0);
    ack();
    key(1); key(2);
    cmp("pre_rst_acc", int'(acc_value), 12);
    reset = 1; tick(); reset = 0;
    cmp("mid_rst_acc", int'(acc_value), 0);
    cmp("mid_rst_operand", int'(operand), 0);
    cmp("mid_rst_cnt", int'(digit_count), 0);

    for (int i = 0; i < 250; i++) begin
      digit_sw = ($urandom_range(0, 6) == 0) ?
                 4'($urandom_range(10, 15)) :
                 4'($urandom_range(0, 9));
      op_sw = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) < 2) begin
        reset = 1; tick(); reset = 0;
      end
      digit_btn = ($urandom_range(0, 99) < 55);
      enter_btn = ($urandom_range(0, 99) < 20);
      clear_btn = ($urandom_range(0, 99) < 8);
      len = $urandom_range(1, 9);
      gap = $urandom_range(0, 10);
      for (int k = 0; k < len; k++) begin
        operand_ack = ($urandom_range(0, 3) == 0);
        tick();
      end
      digit_btn = 0; enter_btn = 0; clear_btn = 0;
      for (int k = 0; k < gap; k++) begin
        operand_ack = ($urandom_range(0, 3) == 0);
        tick();
      end
    end
    operand_ack = 0;
    ticks(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
